// File: rtl/shreg_vdelay.sv
// rtl/shreg_vdelay.sv - runtime-selectable delay line with valid tracking, flush and primed flag
module shreg_vdelay #(
    parameter int WIDTH     = 64,
    parameter int DEPTH_MAX = 16,
    parameter int OUT_REG   = 0
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               en,
    input  logic                               flush,
    input  logic [$clog2(DEPTH_MAX + 1) - 1:0] dly,
    input  logic [WIDTH-1:0]                   i,
    input  logic                               i_valid,
    output logic [WIDTH-1:0]                   o,
    output logic                               o_valid,
    output logic                               primed
);

    localparam int            DW   = $clog2(DEPTH_MAX + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH_MAX);

    logic [WIDTH-1:0]     data_q [DEPTH_MAX];
    logic [WIDTH-1:0]     data_d [DEPTH_MAX];
    logic [DEPTH_MAX-1:0] valid_q, valid_d;
    logic [DW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        dly_eff;
    logic [WIDTH-1:0]     tap_data;
    logic                 tap_valid;
    logic [WIDTH-1:0]     o_d;
    logic                 o_valid_d;
    logic                 primed_d;

    // Clamp the requested delay into 1..DEPTH_MAX
    always_comb begin
        dly_eff = dly;
        if (dly == '0) begin
            dly_eff = DW'(1);
        end else if (dly > DMAX) begin
            dly_eff = DMAX;
        end
    end

    // Shift data and valid bits on enable; flush wipes every valid bit including the incoming one
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en) begin
            data_d[0]  = i;
            valid_d[0] = i_valid;
            for (int k = 1; k < DEPTH_MAX; k++) begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Fill counter: counts enabled non-flush shifts, saturating at DEPTH_MAX
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (en && (cnt_q < DMAX)) begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    // Control state: valid bits and fill counter clear asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data storage carries no reset so it can map onto shift-register primitives
    always_ff @(posedge CLK) begin
        data_q <= data_d;
    end

    // Select the tap at stage dly_eff-1 and mask data with its valid bit
    always_comb begin
        tap_data  = '0;
        tap_valid = 1'b0;
        for (int k = 0; k < DEPTH_MAX; k++) begin
            if (dly_eff == DW'(k + 1)) begin
                tap_data  = data_q[k];
                tap_valid = valid_q[k];
            end
        end
        o_valid_d = tap_valid;
        o_d       = tap_valid ? tap_data : '0;
        primed_d  = (cnt_q >= dly_eff);
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] o_q;
            logic             o_valid_q;
            logic             primed_q;

            // Output register loads every cycle regardless of enable
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    o_q       <= '0;
                    o_valid_q <= 1'b0;
                    primed_q  <= 1'b0;
                end else begin
                    o_q       <= o_d;
                    o_valid_q <= o_valid_d;
                    primed_q  <= primed_d;
                end
            end

            assign o       = o_q;
            assign o_valid = o_valid_q;
            assign primed  = primed_q;
        end else begin : g_ocomb
            assign o       = o_d;
            assign o_valid = o_valid_d;
            assign primed  = primed_d;
        end
    endgenerate

endmodule

// File: tb/tb_shreg_vdelay.sv
// tb/tb_shreg_vdelay.sv - self-checking bench for shreg_vdelay (combinational and registered outputs)
module tb_shreg_vdelay;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic [4:0] dly;
    logic [7:0] din;
    logic       din_v;
    logic [7:0] o0, o1;
    logic       ov0, ov1, pr0, pr1;

    int n_chk  = 0;
    int n_fail = 0;

    shreg_vdelay #(.WIDTH(8), .DEPTH_MAX(16), .OUT_REG(0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .en(en), .flush(flush), .dly(dly),
        .i(din), .i_valid(din_v), .o(o0), .o_valid(ov0), .primed(pr0)
    );

    shreg_vdelay #(.WIDTH(8), .DEPTH_MAX(16), .OUT_REG(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .en(en), .flush(flush), .dly(dly),
        .i(din), .i_valid(din_v), .o(o1), .o_valid(ov1), .primed(pr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: history of accepted samples, newest first
    typedef struct {
        logic [7:0] d;
        bit         v;
    } ent_t;

    ent_t       hist[$];
    int         m_cnt = 0;
    logic [7:0] r_o   = '0;
    bit         r_ov  = 1'b0;
    bit         r_pr  = 1'b0;

    function automatic int eff(input int d);
        if (d == 0) return 1;
        if (d > 16) return 16;
        return d;
    endfunction

    task automatic model_out(output logic [7:0] mo, output bit mv, output bit mp);
        int e;
        e  = eff(int'(dly));
        mo = '0;
        mv = 1'b0;
        if (hist.size() >= e && hist[e-1].v) begin
            mo = hist[e-1].d;
            mv = 1'b1;
        end
        mp = (m_cnt >= e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_now();
        logic [7:0] mo;
        bit         mv, mp;
        model_out(mo, mv, mp);
        chk("model_o",       64'(o0),  64'(mo));
        chk("model_o_valid", 64'(ov0), 64'(mv));
        chk("model_primed",  64'(pr0), 64'(mp));
        chk("reg_o",         64'(o1),  64'(r_o));
        chk("reg_o_valid",   64'(ov1), 64'(r_ov));
        chk("reg_primed",    64'(pr1), 64'(r_pr));
    endtask

    // One clock edge: update the model from the applied inputs, then check at the falling edge
    task automatic tick();
        logic [7:0] mo;
        bit         mv, mp;
        ent_t       e;
        @(posedge clk);
        if (rst_n) begin
            model_out(mo, mv, mp);
            r_o  = mo;
            r_ov = mv;
            r_pr = mp;
            if (en) begin
                e.d = din;
                e.v = din_v && !flush;
                hist.push_front(e);
                if (hist.size() > 16) void'(hist.pop_back());
            end
            if (flush) begin
                foreach (hist[k]) hist[k].v = 1'b0;
                m_cnt = 0;
            end else if (en && m_cnt < 16) begin
                m_cnt++;
            end
        end else begin
            r_o  = '0;
            r_ov = 1'b0;
            r_pr = 1'b0;
        end
        @(negedge clk);
        check_now();
    endtask

    // Asynchronous reset pulse asserted between edges, released on a falling edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        foreach (hist[k]) hist[k].v = 1'b0;
        m_cnt = 0;
        r_o   = '0;
        r_ov  = 1'b0;
        r_pr  = 1'b0;
        chk("rst_o",        64'(o0),  64'(0));
        chk("rst_o_valid",  64'(ov0), 64'(0));
        chk("rst_primed",   64'(pr0), 64'(0));
        chk("rst_reg_o",    64'(o1),  64'(0));
        chk("rst_reg_valid",64'(ov1), 64'(0));
        chk("rst_reg_prim", 64'(pr1), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        check_now();
    endtask

    typedef struct {
        bit         rst_before;
        bit         en;
        logic [4:0] dly;
        logic [7:0] i;
        bit         iv;
        logic [7:0] eo;
        bit         eov;
        bit         epr;
    } vec_t;

    vec_t vt[13];

    initial begin
        // Basic delay, dly=5
        for (int k = 0; k < 7; k++) begin
            vt[k] = '{(k == 0), 1'b1, 5'd5, 8'(k + 1), 1'b1, 8'h00, 1'b0, 1'b0};
        end
        vt[4].eo = 8'd1; vt[4].eov = 1'b1; vt[4].epr = 1'b1;
        vt[5].eo = 8'd2; vt[5].eov = 1'b1; vt[5].epr = 1'b1;
        vt[6].eo = 8'd3; vt[6].eov = 1'b1; vt[6].epr = 1'b1;
        // Enable gaps, dly=3
        vt[7]  = '{1'b1, 1'b1, 5'd3, 8'hA1, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 5'd3, 8'hEE, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 5'd3, 8'hA2, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 5'd3, 8'hEE, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 5'd3, 8'hA3, 1'b1, 8'hA1, 1'b1, 1'b1};
        vt[12] = '{1'b0, 1'b0, 5'd3, 8'hEE, 1'b1, 8'hA1, 1'b1, 1'b1};

        rst_n = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
        dly   = 5'd1;
        din   = '0;
        din_v = 1'b0;
        #3;
        check_now();
        chk("init_o_valid", 64'(ov0), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 13; n++) begin
            if (vt[n].rst_before) do_reset();
            en    = vt[n].en;
            flush = 1'b0;
            dly   = vt[n].dly;
            din   = vt[n].i;
            din_v = vt[n].iv;
            tick();
            chk($sformatf("vec%0d_o", n),       64'(o0),  64'(vt[n].eo));
            chk($sformatf("vec%0d_o_valid", n), 64'(ov0), 64'(vt[n].eov));
            chk($sformatf("vec%0d_primed", n),  64'(pr0), 64'(vt[n].epr));
        end

        // dly=0 behaves as 1
        do_reset();
        en = 1'b1; dly = 5'd0; din = 8'h55; din_v = 1'b1;
        tick();
        chk("dly0_o", 64'(o0), 64'h55);
        chk("dly0_o_valid", 64'(ov0), 64'(1));
        chk("dly0_primed", 64'(pr0), 64'(1));

        // dly=20 clamps to 16, then runtime change 8 -> 2
        do_reset();
        dly = 5'd20;
        for (int k = 0; k < 16; k++) begin
            din = 8'(8'h10 + k);
            tick();
            if (k == 14) chk("dly20_early_valid", 64'(ov0), 64'(0));
        end
        chk("dly20_o", 64'(o0), 64'h10);
        chk("dly20_primed", 64'(pr0), 64'(1));
        dly = 5'd8;
        #1;
        chk("dly8_o", 64'(o0), 64'h18);
        dly = 5'd2;
        #1;
        chk("dly2_o", 64'(o0), 64'h1E);
        check_now();

        // Flush during a stream, dly=4
        do_reset();
        dly = 5'd4;
        for (int k = 0; k < 6; k++) begin
            din = 8'(8'h30 + k);
            tick();
        end
        chk("pre_flush_o", 64'(o0), 64'h32);
        flush = 1'b1; din = 8'h36;
        tick();
        chk("flush_o_valid", 64'(ov0), 64'(0));
        chk("flush_primed", 64'(pr0), 64'(0));
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            din = 8'(8'h40 + k);
            tick();
            chk("post_flush_o_valid", 64'(ov0), 64'((k == 3) ? 1 : 0));
        end
        chk("post_flush_o", 64'(o0), 64'h40);

        // Async reset while o_valid=1, then refill
        do_reset();
        for (int k = 0; k < 4; k++) begin
            din = 8'(8'h50 + k);
            tick();
            chk("refill_o_valid", 64'(ov0), 64'((k == 3) ? 1 : 0));
        end
        chk("refill_o", 64'(o0), 64'h50);
        tick();
        chk("reg_lag_o", 64'(o1), 64'h50);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            en    = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            din   = 8'($urandom);
            din_v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dly = 5'($urandom_range(0, 20));
            if ($urandom_range(0, 149) == 0) begin
                flush = 1'b0;
                do_reset();
            end
            tick();
            if ($urandom_range(0, 9) == 0) begin
                dly = 5'($urandom_range(0, 20));
                #1;
                check_now();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
